// File: rtl/vgpr_contention_stats.sv
// vgpr_contention_stats: per-wavefront VGPR bank access/contention counters with a 4-entry record FIFO.
module vgpr_contention_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dispatch,
  input  logic [2:0]  rd_en,
  input  logic [11:0] rd_bank,
  input  logic        alu_wr_en,
  input  logic [3:0]  alu_wr_bank,
  input  logic [3:0]  lsu_wr_en,
  input  logic [3:0]  lsu_wr_bank,
  input  logic        wf_done_en,
  input  logic [5:0]  wf_done_wfid,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [5:0]  rec_wfid,
  output logic [31:0] rec_access,
  output logic [31:0] rec_contention,
  output logic        drop_sticky,
  output logic        active
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic [5:0]  wfid;
    logic [31:0] acc;
    logic [31:0] cont;
  } rec_t;
  state_t      state;
  logic [31:0] acc_cnt, cont_cnt, acc_nxt, cont_nxt;
  logic [7:0]  slot_en;
  logic [3:0]  slot_bank [8];
  logic [3:0]  hit [16];
  logic [3:0]  cyc_access;
  logic [2:0]  cyc_cont;
  logic        done, pop, push, drop;
  logic [1:0]  wptr, rptr;
  logic [2:0]  count;
  rec_t        mem [4];
  rec_t        head;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      slot_en[k]   = rd_en[k];
      slot_bank[k] = rd_bank[4*k +: 4];
    end
    slot_en[3]   = alu_wr_en;
    slot_bank[3] = alu_wr_bank;
    for (int k = 0; k < 4; k++) begin
      slot_en[4+k]   = lsu_wr_en[k];
      slot_bank[4+k] = lsu_wr_bank + 4'(k);
    end
  end
  always_comb begin
    for (int b = 0; b < 16; b++) begin
      hit[b] = '0;
      for (int s = 0; s < 8; s++) hit[b] = hit[b] + 4'(slot_en[s] && slot_bank[s] == 4'(b));
    end
  end
  always_comb begin
    cyc_access = '0;
    cyc_cont   = '0;
    for (int s = 0; s < 8; s++) cyc_access = cyc_access + 4'(slot_en[s]);
    for (int b = 0; b < 16; b++) cyc_cont = cyc_cont + 3'(hit[b] > 4'd1);
  end
  assign acc_nxt  = sat_add(acc_cnt, cyc_access);
  assign cont_nxt = sat_add(cont_cnt, {1'b0, cyc_cont});
  assign done     = wf_done_en && state == ACTIVE;
  assign pop      = count != 3'd0 && rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = done && (count != 3'd4 || pop);
  assign drop     = done && count == 3'd4 && !pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_cnt     <= '0;
      cont_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      drop_sticky <= 1'b0;
    end else begin
      if (state == IDLE && dispatch) state <= ACTIVE;
      if (state == ACTIVE) begin
        acc_cnt  <= done ? '0 : acc_nxt;
        cont_cnt <= done ? '0 : cont_nxt;
      end
      wptr        <= wptr + 2'(push);
      rptr        <= rptr + 2'(pop);
      count       <= count + 3'(push) - 3'(pop);
      drop_sticky <= drop_sticky | drop;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{wfid: wf_done_wfid, acc: acc_nxt, cont: cont_nxt};
  end
  assign head           = mem[rptr];
  assign rec_valid      = count != 3'd0;
  assign rec_wfid       = rec_valid ? head.wfid : '0;
  assign rec_access     = rec_valid ? head.acc : '0;
  assign rec_contention = rec_valid ? head.cont : '0;
  assign active         = state == ACTIVE;
endmodule

// File: tb/tb_vgpr_contention_stats.sv
// tb_vgpr_contention_stats: scoreboard bench with directed vectors for vgpr_contention_stats.
module tb_vgpr_contention_stats;
  logic        clk = 1'b0;
  logic        rst_n, dispatch, alu_wr_en, wf_done_en, rec_ready;
  logic [2:0]  rd_en;
  logic [11:0] rd_bank;
  logic [3:0]  alu_wr_bank, lsu_wr_en, lsu_wr_bank;
  logic [5:0]  wf_done_wfid;
  logic        rec_valid, drop_sticky, active;
  logic [5:0]  rec_wfid;
  logic [31:0] rec_access, rec_contention;
  int          checks = 0, passes = 0;
  logic [69:0] exp_q [$];
  vgpr_contention_stats dut (
    .clk(clk), .rst_n(rst_n), .dispatch(dispatch), .rd_en(rd_en), .rd_bank(rd_bank),
    .alu_wr_en(alu_wr_en), .alu_wr_bank(alu_wr_bank), .lsu_wr_en(lsu_wr_en),
    .lsu_wr_bank(lsu_wr_bank), .wf_done_en(wf_done_en), .wf_done_wfid(wf_done_wfid),
    .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_wfid(rec_wfid),
    .rec_access(rec_access), .rec_contention(rec_contention),
    .drop_sticky(drop_sticky), .active(active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic cyc(input logic dsp, input logic [2:0] re, input logic [11:0] rb,
                     input logic ae, input logic [3:0] ab, input logic [3:0] le,
                     input logic [3:0] lb, input logic dn, input logic [5:0] wf);
    dispatch = dsp; rd_en = re; rd_bank = rb; alu_wr_en = ae; alu_wr_bank = ab;
    lsu_wr_en = le; lsu_wr_bank = lb; wf_done_en = dn; wf_done_wfid = wf;
    @(posedge clk); #1;
    dispatch = 0; rd_en = 0; rd_bank = 0; alu_wr_en = 0; alu_wr_bank = 0;
    lsu_wr_en = 0; lsu_wr_bank = 0; wf_done_en = 0; wf_done_wfid = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drain;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain_left", 70'(exp_q.size()), 70'd0);
  endtask
  always @(negedge clk) begin
    if (rec_valid && rec_ready) begin
      if (exp_q.size() == 0) chk("unexpected_record", {rec_wfid, rec_access, rec_contention}, 70'd0);
      else chk("record", {rec_wfid, rec_access, rec_contention}, exp_q.pop_front());
    end
  end
  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; rec_ready = 1;
    dispatch = 0; rd_en = 0; rd_bank = 0; alu_wr_en = 0; alu_wr_bank = 0;
    lsu_wr_en = 0; lsu_wr_bank = 0; wf_done_en = 0; wf_done_wfid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {60'(rec_valid), rec_wfid, rec_access[0], rec_contention[0], drop_sticky, active}, 70'd0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) cyc(0, 3'b111, 12'h210, 0, 0, 0, 0, 0, 0);
    cyc(0, 3'b111, 12'h210, 0, 0, 0, 0, 1, 6'd1);
    idle(2);
    chk("idle_no_record", 70'(rec_valid), 70'd0);
    chk("idle_inactive", 70'(active), 70'd0);
    cyc(1, 3'b111, 12'h555, 0, 0, 0, 0, 0, 0);
    chk("active_after_dispatch", 70'(active), 70'd1);
    exp_q.push_back({6'd2, 32'd4, 32'd1});
    cyc(0, 3'b111, 12'h555, 1, 4'd5, 0, 0, 1, 6'd2);
    exp_q.push_back({6'd3, 32'd8, 32'd1});
    cyc(0, 3'b111, 12'h555, 1, 4'd5, 4'b1111, 4'd14, 1, 6'd3);
    cyc(0, 3'b111, 12'h211, 0, 0, 0, 0, 0, 0);
    cyc(0, 3'b011, 12'h077, 1, 4'd8, 0, 0, 0, 0);
    exp_q.push_back({6'd9, 32'd8, 32'd3});
    cyc(0, 3'b001, 12'h003, 1, 4'd3, 0, 0, 1, 6'd9);
    exp_q.push_back({6'd10, 32'd1, 32'd0});
    cyc(0, 3'b001, 12'h004, 0, 0, 0, 0, 1, 6'd10);
    drain();
    chk("no_drop_yet", 70'(drop_sticky), 70'd0);
    rec_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({6'(20 + i), 32'd1, 32'd0});
      if (i == 4) chk("drop_before_overflow", 70'(drop_sticky), 70'd0);
      cyc(0, 3'b001, 12'(i), 0, 0, 0, 0, 1, 6'(20 + i));
    end
    chk("drop_sticky_set", 70'(drop_sticky), 70'd1);
    chk("head_held", {rec_wfid, rec_access, rec_contention}, {6'd20, 32'd1, 32'd0});
    rec_ready = 1;
    exp_q.push_back({6'd26, 32'd2, 32'd1});
    cyc(0, 3'b011, 12'h066, 0, 0, 0, 0, 1, 6'd26);
    rec_ready = 0;
    chk("fifo_full_after_push_pop", 70'(dut.count), 70'd4);
    idle(1);
    rec_ready = 1;
    drain();
    force dut.acc_cnt = 32'hFFFF_FFFE;
    #1 release dut.acc_cnt;
    cyc(0, 3'b111, 12'h210, 0, 0, 0, 0, 0, 0);
    chk("acc_saturated", 70'(dut.acc_cnt), 70'hFFFF_FFFF);
    exp_q.push_back({6'd30, 32'hFFFF_FFFF, 32'd0});
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6'd30);
    drain();
    rec_ready = 0;
    cyc(0, 3'b001, 12'h001, 0, 0, 0, 0, 1, 6'd40);
    cyc(0, 3'b001, 12'h001, 0, 0, 0, 0, 1, 6'd41);
    cyc(0, 3'b111, 12'h222, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_reset_out", {60'(rec_valid), rec_wfid, |rec_access, |rec_contention, drop_sticky, active}, 70'd0);
    chk("async_reset_payload", {6'd0, rec_access, rec_contention}, 70'd0);
    @(posedge clk); #1;
    rst_n = 1; rec_ready = 1;
    cyc(0, 3'b111, 12'h210, 0, 0, 0, 0, 1, 6'd42);
    idle(2);
    chk("post_reset_no_record", 70'(rec_valid), 70'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({6'd43, 32'd2, 32'd1});
    cyc(0, 3'b001, 12'h009, 1, 4'd9, 0, 0, 1, 6'd43);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vgpr_contention_stats.md
VGPR_CONTENTION_STATS -- requirements
Module: vgpr_contention_stats

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous active-low reset).
REQ-002 SHALL have input dispatch, 1 bit: first-dispatch pulse that arms the block.
REQ-003 SHALL have input rd_en, 3 bits: per read port (src1..src3) valid.
REQ-004 SHALL have input rd_bank, 12 bits: bank of read port k in [4k+3:4k].
REQ-005 SHALL have inputs alu_wr_en (1 bit) and alu_wr_bank (4 bits): ALU writeback valid and bank.
REQ-006 SHALL have inputs lsu_wr_en (4 bits) and lsu_wr_bank (4 bits): LSU dword write enables and base bank.
REQ-007 SHALL have inputs wf_done_en (1 bit) and wf_done_wfid (6 bits): wavefront completion pulse and its id.
REQ-008 SHALL have input rec_ready, 1 bit: consumer accepts the record.
REQ-009 SHALL have output rec_valid, 1 bit: record available.
REQ-010 SHALL have outputs rec_wfid (6 bits), rec_access (32 bits) and rec_contention (32 bits): the record payload.
REQ-011 SHALL have output drop_sticky, 1 bit: a record was lost because the FIFO was full.
REQ-012 SHALL have output active, 1 bit: the FSM is in ACTIVE.

Function
REQ-013 SHALL implement FSM IDLE->ACTIVE on dispatch=1 sampled at a clock edge; ACTIVE is held until reset; there are no other transitions.
REQ-014 In IDLE, SHALL ignore all access inputs and wf_done_en; counters hold 0.
REQ-015 SHALL form per cycle 8 access slots: rd_en[k] to bank rd_bank[k]; alu_wr_en to alu_wr_bank; lsu_wr_en[k] to bank (lsu_wr_bank+k) mod 16, for k = 0..3.
REQ-016 SHALL compute per-bank hit counts (0..8) combinationally for each cycle.
REQ-017 SHALL set cyc_access = number of enabled slots (0..8) and cyc_cont = number of banks with hit count >1 (0..4).
REQ-018 In ACTIVE, SHALL update acc_cnt and cont_cnt (32-bit) each cycle as acc_cnt += cyc_access and cont_cnt += cyc_cont, both saturating at 0xFFFFFFFF.
REQ-019 On wf_done_en in ACTIVE, SHALL form the record {wf_done_wfid, acc_cnt+cyc_access, cont_cnt+cyc_cont}, saturated, so the same-cycle accesses are included.
REQ-020 On wf_done_en in ACTIVE, SHALL clear both counters to 0 at that edge, so the next window starts empty.
REQ-021 SHALL hold records in a 4-entry FIFO; the rec_* outputs present the head entry; rec_valid = FIFO not empty.
REQ-022 Latency: wf_done_en at edge N SHALL give rec_valid=1 after edge N when the FIFO was empty.
REQ-023 Handshake: a pop SHALL occur at an edge when rec_valid=1 and rec_ready=1; the payload SHALL remain stable while rec_valid=1 and rec_ready=0.
REQ-024 Full FIFO with no pop at a wf_done edge: SHALL discard the record, set drop_sticky=1, and still clear the counters.
REQ-025 Full FIFO with a pop in the same cycle as wf_done: SHALL perform the push and the pop, so the FIFO stays full and nothing is dropped.
REQ-026 Empty FIFO: rec_ready SHALL be ignored; there is no bypass to the outputs in the push cycle.
REQ-027 SHALL wrap the FIFO read and write pointers mod 4, with a 3-bit occupancy count from 0 to 4.

Reset
REQ-028 When rst_n=0, SHALL asynchronously force state IDLE, counters 0, FIFO empty, rec_valid=0, rec_wfid=0, rec_access=0, rec_contention=0, drop_sticky=0 and active=0.
REQ-029 Reset mid-operation SHALL discard all pending records; after release the block waits for a new dispatch.

Verification
REQ-030 Scenario: before dispatch, drive rd_en=3'b111 for 10 cycles, then wf_done_en -> rec_valid stays 0.
REQ-031 Scenario: after dispatch, for one cycle drive rd_en=3'b111 with banks 5,5,5 and alu_wr_en=1 to bank 5 -> cyc_access=4, cyc_cont=1.
  - Same cycle adds lsu_wr_en=4'b1111 with base 14 -> extra hits on banks 14,15,0,1, giving access 8 and contention 1.
REQ-032 Scenario: accesses totalling 6 with 2 contention, followed by wf_done_en with wfid 9 in a cycle carrying 2 accesses to bank 3 -> next cycle record {9, 8, 3}; the following window starts at 0.
REQ-033 Scenario: rec_ready=0, five wf_done pulses -> 4 records retained in order, drop_sticky=1.
  - A sixth wf_done pulse in the same cycle as a pop with rec_ready=1 -> no further loss; FIFO holds 4 entries.
REQ-034 Scenario: preload acc_cnt to 0xFFFFFFFE via long stimulus or force, then one cycle with 3 accesses -> acc_cnt=0xFFFFFFFF.
REQ-035 Scenario: rst_n asserted with 2 records queued and non-zero counters -> outputs zero immediately.
  - After rst_n is released: no record until a new dispatch and wf_done.
